mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single memory-controller port between icache and dcache. Forwards one
//  requester's command per cycle. Records which requester owns each returned memory
//  tag, and routes each tag/data completion back to that owner only.
//  Sits between the two caches and the controller.
// PARAMETERS
//  MAX_WAIT   default 4   consecutive cycles a requester may lose before it takes priority
//  TAG_W      default 4   memory tag width; tag 0 means "no response / no tag"
// PORTS
//  clock                 in   1       system clock
//  reset                 in   1       asynchronous, active-low reset
//  ic2arb_command        in   2       icache BUS_NONE/BUS_LOAD
//  ic2arb_addr           in   XLEN    icache request address, 8B aligned
//  arb2ic_response       out  TAG_W   nonzero = icache request accepted, with this tag
//  arb2ic_tag            out  TAG_W   completion tag to icache (0 if not icache's)
//  arb2ic_data           out  64      completion data to icache
//  dc2arb_command        in   2       dcache BUS_NONE/BUS_LOAD/BUS_STORE
//  dc2arb_addr           in   XLEN    dcache request address
//  dc2arb_data           in   64      dcache store data
//  arb2dc_response       out  TAG_W   nonzero = dcache request accepted, with this tag
//  arb2dc_tag            out  TAG_W   completion tag to dcache
//  arb2dc_data           out  64      completion data to dcache
//  proc2mem_command      out  2       forwarded command
//  proc2mem_addr         out  XLEN    forwarded address
//  proc2mem_data         out  64      forwarded store data
//  mem2proc_response     in   TAG_W   controller acceptance tag (0 = busy / not accepted)
//  mem2proc_tag          in   TAG_W   completion tag
//  mem2proc_data         in   64      completion data
//  arb_err               out  1       sticky: completion seen for an unowned tag
// BEHAVIOUR
//  - Request path is combinational. A requester sees its response in the same cycle,
//    and advances on a nonzero response, as the caches expect.
//  - FSM (grant lock): IDLE, LOCK_IC, LOCK_DC.
//    - IDLE:
//      - Grant the requester with command != BUS_NONE.
//      - Both requesting: starved requester wins (wait_cnt == MAX_WAIT), else dcache.
//      - Granted and response == 0 -> go to LOCK_<granted>. Keep the same grant next
//        cycle so the controller sees a stable request.
//      - Response != 0 -> stay IDLE.
//    - LOCK_x: grant x unconditionally.
//      - Leave to IDLE on nonzero response.
//      - Leave to IDLE if x drops its command to BUS_NONE.
//  - Ungranted side: response forced to 0. Forwarded bus = BUS_NONE, addr 0, data 0
//    when nobody is granted.
//  - Starvation counters:
//    - One wait_cnt per requester, saturating at MAX_WAIT.
//    - Increments each cycle the requester requests but is not accepted.
//    - Clears on acceptance or on BUS_NONE.
//  - Owner table: 2^TAG_W entries of {valid, owner}, entry 0 never written.
//    - On nonzero response, entry[response] <= {1, granted}.
//    - On nonzero completion tag: if entry[tag].valid, drive tag/data to the owner only
//      (other side tag = 0, data = 0), then clear valid.
//    - If entry[tag] is not valid: drop the completion and set arb_err.
//  - Same cycle, tag T accepted and tag T completed: the completion uses the
//    pre-cycle entry, and the new allocation wins the write. Net entry = {1, new owner}.
//  - Reset (async, any time): FSM -> IDLE, counters 0, all valid bits 0, arb_err 0.
//    All outputs 0 / BUS_NONE.
//    - A request in flight at reset is abandoned.
//    - Its later completion sets arb_err.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    - Adds 32-bit saturating counters, readable on extra outputs: ic_grants,
//      dc_grants, busy_cycles (granted with response 0), starve_events (wait_cnt
//      reached MAX_WAIT).
//    - Counters clear on reset.
//  ARB_STATS_EN undefined: no counters and no extra ports. Behaviour is otherwise
//    identical.
// STRUCTURE
//  - Shared package (sys_defs): BUS_NONE/BUS_LOAD/BUS_STORE, XLEN,
//    ARB_OWNER_T {OWN_IC, OWN_DC}, ARB_STATE_T {IDLE, LOCK_IC, LOCK_DC},
//    ARB_TAG_ENTRY typedef {valid, owner}.
//  - One sub-module: arb_tag_table. It holds the owner table with one write port
//    (alloc) and one read-and-clear port (complete), and encodes the same-cycle rule.
// TESTING
//  1. dc LOAD 0x100 and ic LOAD 0x200 in the same cycle, mem response=3
//     -> dcache gets response 3, ic response 0, proc2mem_addr=0x100.
//     Later mem tag 3 -> arb2dc_tag=3, arb2ic_tag=0.
//  2. ic LOAD with mem response 0 for 3 cycles while dc also requests
//     -> FSM LOCK_IC, proc2mem_addr stays ic addr. Response 5 -> arb2ic_response=5,
//     FSM IDLE.
//  3. dc requests every cycle, ic requests continuously -> ic granted no later than
//     the cycle after its wait_cnt reaches 4.
//  4. Accept tag 7 for dc. In the same cycle as the dc tag-7 completion, accept a new
//     ic request with tag 7 -> completion goes to dcache, and the next tag-7
//     completion goes to icache.
//  5. Completion tag 9 with no allocation -> both side tags 0, arb_err=1 and sticky.
//  6. Assert reset mid-LOCK_DC -> outputs 0/BUS_NONE immediately.
//     After release, the old tag's completion sets arb_err.

Source files
------------

// File: rtl/sys_defs.sv
// ----------------------------------------------------------------------------
// sys_defs
//   Shared definitions for the memory-bus arbiter and the caches around it:
//   bus command encodings, address width, owner/state enums, the owner-table
//   entry type, and a saturating increment used by the optional statistics.
// ----------------------------------------------------------------------------
package sys_defs;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } ARB_OWNER_T;

    typedef enum logic [1:0] {
        IDLE    = 2'h0,
        LOCK_IC = 2'h1,
        LOCK_DC = 2'h2
    } ARB_STATE_T;

    typedef struct packed {
        logic       valid;
        ARB_OWNER_T owner;
    } ARB_TAG_ENTRY;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/arb_tag_table.sv
// ----------------------------------------------------------------------------
// arb_tag_table
//   Records which requester owns each outstanding memory tag.
//   One write port (alloc) claims an entry; one read-and-clear port (complete)
//   looks up the owner of a returning tag and frees the entry. Entry 0 is never
//   written because tag 0 means "no tag".
//   When the same tag is completed and re-allocated in one cycle, the lookup
//   sees the old entry and the new allocation is what remains afterwards.
//
// Ports
//   clock        in   1      system clock
//   reset        in   1      asynchronous, active-low reset (clears all valids)
//   alloc_en     in   1      claim entry alloc_tag for alloc_owner this cycle
//   alloc_tag    in   TAG_W  tag being claimed
//   alloc_owner  in   1      requester that owns the claimed tag
//   comp_tag     in   TAG_W  completion tag (0 = none)
//   comp_hit     out  1      comp_tag is nonzero and currently owned
//   comp_owner   out  1      owner of comp_tag (meaningful only with comp_hit)
// ----------------------------------------------------------------------------
module arb_tag_table
    import sys_defs::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  ARB_OWNER_T       alloc_owner,
    input  logic [TAG_W-1:0] comp_tag,
    output logic             comp_hit,
    output ARB_OWNER_T       comp_owner
);

    localparam int DEPTH = 1 << TAG_W;

    ARB_TAG_ENTRY [DEPTH-1:0] entries_q;
    ARB_TAG_ENTRY [DEPTH-1:0] entries_d;

    always_comb begin
        comp_hit   = (comp_tag != '0) && entries_q[comp_tag].valid;
        comp_owner = entries_q[comp_tag].owner;

        entries_d = entries_q;
        if (comp_hit) begin
            entries_d[comp_tag].valid = 1'b0;
        end
        // Applied after the clear so a same-cycle re-allocation of the
        // completing tag survives.
        if (alloc_en && (alloc_tag != '0)) begin
            entries_d[alloc_tag].valid = 1'b1;
            entries_d[alloc_tag].owner = alloc_owner;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single memory-controller port between icache and dcache.
//   One requester's command is forwarded per cycle; the acceptance tag from the
//   controller is passed straight back to that requester in the same cycle.
//   Each accepted tag is recorded with its owner so the completion (tag + data)
//   is routed to that owner only. Completions for unowned tags are dropped and
//   raise the sticky arb_err flag.
//
//   Grant lock: once a requester is granted and the controller stalls
//   (response 0), the grant is held on that requester until it is accepted or
//   withdraws, so the controller sees a stable request.
//   Starvation: a requester that has lost MAX_WAIT consecutive cycles wins the
//   next contested arbitration; otherwise the dcache wins ties.
//
//   Optional build macro ARB_STATS_EN adds saturating 32-bit counters
//   ic_grants, dc_grants, busy_cycles and starve_events on extra outputs.
//
// Ports
//   clock, reset            clock; asynchronous active-low reset
//   ic2arb_command/addr     icache request
//   arb2ic_response         acceptance tag for icache (0 = not accepted)
//   arb2ic_tag/data         completion routed to icache (0 when not icache's)
//   dc2arb_command/addr/data dcache request (data used by stores)
//   arb2dc_response         acceptance tag for dcache
//   arb2dc_tag/data         completion routed to dcache
//   proc2mem_command/addr/data forwarded request (BUS_NONE/0 when no grant)
//   mem2proc_response       controller acceptance tag (0 = busy)
//   mem2proc_tag/data       controller completion
//   arb_err                 sticky: completion for an unowned tag
//   ic_grants, dc_grants, busy_cycles, starve_events   (ARB_STATS_EN only)
// ----------------------------------------------------------------------------
module mem_bus_arbiter
    import sys_defs::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int TAG_W    = 4
) (
    input  logic             clock,
    input  logic             reset,

    input  logic [1:0]       ic2arb_command,
    input  logic [XLEN-1:0]  ic2arb_addr,
    output logic [TAG_W-1:0] arb2ic_response,
    output logic [TAG_W-1:0] arb2ic_tag,
    output logic [63:0]      arb2ic_data,

    input  logic [1:0]       dc2arb_command,
    input  logic [XLEN-1:0]  dc2arb_addr,
    input  logic [63:0]      dc2arb_data,
    output logic [TAG_W-1:0] arb2dc_response,
    output logic [TAG_W-1:0] arb2dc_tag,
    output logic [63:0]      arb2dc_data,

    output logic [1:0]       proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [TAG_W-1:0] mem2proc_tag,
    input  logic [63:0]      mem2proc_data,

    output logic             arb_err
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]      ic_grants,
    output logic [31:0]      dc_grants,
    output logic [31:0]      busy_cycles,
    output logic [31:0]      starve_events
`endif
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    ARB_STATE_T        state_q, state_d;
    logic [WAIT_W-1:0] ic_wait_q, ic_wait_d;
    logic [WAIT_W-1:0] dc_wait_q, dc_wait_d;
    logic              arb_err_q, arb_err_d;

    logic              ic_req, dc_req;
    logic              gnt_ic, gnt_dc;
    logic              mem_acc, ic_acc, dc_acc;
    logic              comp_valid, comp_hit;
    ARB_OWNER_T        comp_owner;
    logic              route_ic, route_dc;

    // Grant selection. Requests are masked while reset is asserted so every
    // output collapses to 0 / BUS_NONE immediately, independent of the caches.
    always_comb begin
        ic_req = reset && (ic2arb_command != BUS_NONE);
        dc_req = reset && (dc2arb_command != BUS_NONE);
        gnt_ic = 1'b0;
        gnt_dc = 1'b0;
        case (state_q)
            LOCK_IC: gnt_ic = ic_req;
            LOCK_DC: gnt_dc = dc_req;
            default: begin
                if (ic_req && dc_req) begin
                    // dcache wins ties unless only the icache is starved.
                    if ((ic_wait_q == WAIT_MAX) && (dc_wait_q != WAIT_MAX)) begin
                        gnt_ic = 1'b1;
                    end else begin
                        gnt_dc = 1'b1;
                    end
                end else begin
                    gnt_ic = ic_req;
                    gnt_dc = dc_req;
                end
            end
        endcase

        mem_acc = (mem2proc_response != '0);
        ic_acc  = gnt_ic && mem_acc;
        dc_acc  = gnt_dc && mem_acc;
    end

    // Forwarded request and same-cycle acceptance responses.
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (gnt_dc) begin
            proc2mem_command = dc2arb_command;
            proc2mem_addr    = dc2arb_addr;
            proc2mem_data    = dc2arb_data;
        end else if (gnt_ic) begin
            proc2mem_command = ic2arb_command;
            proc2mem_addr    = ic2arb_addr;
        end
        arb2ic_response = ic_acc ? mem2proc_response : '0;
        arb2dc_response = dc_acc ? mem2proc_response : '0;
    end

    // Next state, starvation counters and error flag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_ic && !mem_acc) begin
                    state_d = LOCK_IC;
                end else if (gnt_dc && !mem_acc) begin
                    state_d = LOCK_DC;
                end
            end
            LOCK_IC: if (!ic_req || mem_acc) state_d = IDLE;
            LOCK_DC: if (!dc_req || mem_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!ic_req || ic_acc) begin
            ic_wait_d = '0;
        end else if (ic_wait_q == WAIT_MAX) begin
            ic_wait_d = WAIT_MAX;
        end else begin
            ic_wait_d = ic_wait_q + WAIT_ONE;
        end

        if (!dc_req || dc_acc) begin
            dc_wait_d = '0;
        end else if (dc_wait_q == WAIT_MAX) begin
            dc_wait_d = WAIT_MAX;
        end else begin
            dc_wait_d = dc_wait_q + WAIT_ONE;
        end

        arb_err_d = arb_err_q || (comp_valid && !comp_hit);
    end

    // Completion routing: only the recorded owner sees the tag and data.
    always_comb begin
        comp_valid  = reset && (mem2proc_tag != '0);
        route_ic    = comp_valid && comp_hit && (comp_owner == OWN_IC);
        route_dc    = comp_valid && comp_hit && (comp_owner == OWN_DC);
        arb2ic_tag  = route_ic ? mem2proc_tag  : '0;
        arb2ic_data = route_ic ? mem2proc_data : '0;
        arb2dc_tag  = route_dc ? mem2proc_tag  : '0;
        arb2dc_data = route_dc ? mem2proc_data : '0;
    end

    arb_tag_table #(
        .TAG_W (TAG_W)
    ) u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (ic_acc || dc_acc),
        .alloc_tag   (mem2proc_response),
        .alloc_owner (dc_acc ? OWN_DC : OWN_IC),
        .comp_tag    (mem2proc_tag),
        .comp_hit    (comp_hit),
        .comp_owner  (comp_owner)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ic_wait_q <= '0;
            dc_wait_q <= '0;
            arb_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ic_wait_q <= ic_wait_d;
            dc_wait_q <= dc_wait_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q;

`ifdef ARB_STATS_EN
    logic [31:0] ic_grants_q, ic_grants_d;
    logic [31:0] dc_grants_q, dc_grants_d;
    logic [31:0] busy_cycles_q, busy_cycles_d;
    logic [31:0] starve_events_q, starve_events_d;

    // Grants count accepted requests; a starve event is a counter arriving
    // at MAX_WAIT, so a requester parked at the limit counts once.
    always_comb begin
        ic_grants_d     = ic_acc ? sat_inc32(ic_grants_q) : ic_grants_q;
        dc_grants_d     = dc_acc ? sat_inc32(dc_grants_q) : dc_grants_q;
        busy_cycles_d   = ((gnt_ic || gnt_dc) && !mem_acc) ? sat_inc32(busy_cycles_q)
                                                           : busy_cycles_q;
        starve_events_d = starve_events_q;
        if ((ic_wait_d == WAIT_MAX) && (ic_wait_q != WAIT_MAX)) begin
            starve_events_d = sat_inc32(starve_events_d);
        end
        if ((dc_wait_d == WAIT_MAX) && (dc_wait_q != WAIT_MAX)) begin
            starve_events_d = sat_inc32(starve_events_d);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ic_grants_q     <= '0;
            dc_grants_q     <= '0;
            busy_cycles_q   <= '0;
            starve_events_q <= '0;
        end else begin
            ic_grants_q     <= ic_grants_d;
            dc_grants_q     <= dc_grants_d;
            busy_cycles_q   <= busy_cycles_d;
            starve_events_q <= starve_events_d;
        end
    end

    assign ic_grants     = ic_grants_q;
    assign dc_grants     = dc_grants_q;
    assign busy_cycles   = busy_cycles_q;
    assign starve_events = starve_events_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter: inputs change just after the falling
//   edge, outputs are sampled 1 time unit later, far from the rising edge.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    import sys_defs::*;

    localparam int TAG_W = 4;

    logic             clock;
    logic             reset;
    logic [1:0]       ic2arb_command;
    logic [XLEN-1:0]  ic2arb_addr;
    logic [TAG_W-1:0] arb2ic_response;
    logic [TAG_W-1:0] arb2ic_tag;
    logic [63:0]      arb2ic_data;
    logic [1:0]       dc2arb_command;
    logic [XLEN-1:0]  dc2arb_addr;
    logic [63:0]      dc2arb_data;
    logic [TAG_W-1:0] arb2dc_response;
    logic [TAG_W-1:0] arb2dc_tag;
    logic [63:0]      arb2dc_data;
    logic [1:0]       proc2mem_command;
    logic [XLEN-1:0]  proc2mem_addr;
    logic [63:0]      proc2mem_data;
    logic [TAG_W-1:0] mem2proc_response;
    logic [TAG_W-1:0] mem2proc_tag;
    logic [63:0]      mem2proc_data;
    logic             arb_err;

    int n_assert = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(
        .MAX_WAIT (4),
        .TAG_W    (TAG_W)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ic2arb_command    (ic2arb_command),
        .ic2arb_addr       (ic2arb_addr),
        .arb2ic_response   (arb2ic_response),
        .arb2ic_tag        (arb2ic_tag),
        .arb2ic_data       (arb2ic_data),
        .dc2arb_command    (dc2arb_command),
        .dc2arb_addr       (dc2arb_addr),
        .dc2arb_data       (dc2arb_data),
        .arb2dc_response   (arb2dc_response),
        .arb2dc_tag        (arb2dc_tag),
        .arb2dc_data       (arb2dc_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_tag      (mem2proc_tag),
        .mem2proc_data     (mem2proc_data),
        .arb_err           (arb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge, then settle.
    task automatic drive(input logic [1:0] icc, input logic [XLEN-1:0] ica,
                         input logic [1:0] dcc, input logic [XLEN-1:0] dca,
                         input logic [63:0] dcd, input logic [TAG_W-1:0] rsp,
                         input logic [TAG_W-1:0] tg, input logic [63:0] td);
        @(negedge clock);
        ic2arb_command    = icc;
        ic2arb_addr       = ica;
        dc2arb_command    = dcc;
        dc2arb_addr       = dca;
        dc2arb_data       = dcd;
        mem2proc_response = rsp;
        mem2proc_tag      = tg;
        mem2proc_data     = td;
        #1;
    endtask

    task automatic idle(input logic [TAG_W-1:0] tg, input logic [63:0] td);
        drive(BUS_NONE, '0, BUS_NONE, '0, '0, '0, tg, td);
    endtask

    initial begin
        // Reset with busy-looking inputs: everything must read as quiet.
        reset             = 1'b0;
        ic2arb_command    = BUS_LOAD;
        ic2arb_addr       = 32'h200;
        dc2arb_command    = BUS_STORE;
        dc2arb_addr       = 32'h100;
        dc2arb_data       = 64'h1234;
        mem2proc_response = 4'd3;
        mem2proc_tag      = 4'd3;
        mem2proc_data     = 64'hABCD;
        #3;
        chk("rst_cmd",     proc2mem_command, BUS_NONE);
        chk("rst_addr",    proc2mem_addr,    32'h0);
        chk("rst_data",    proc2mem_data,    64'h0);
        chk("rst_ic_resp", arb2ic_response,  4'd0);
        chk("rst_dc_resp", arb2dc_response,  4'd0);
        chk("rst_dc_tag",  arb2dc_tag,       4'd0);
        chk("rst_err",     arb_err,          1'b0);
        @(negedge clock);
        @(negedge clock);
        ic2arb_command    = BUS_NONE;
        dc2arb_command    = BUS_NONE;
        mem2proc_response = '0;
        mem2proc_tag      = '0;
        reset             = 1'b1;

        // 1: simultaneous requests, dcache wins and gets tag 3.
        drive(BUS_LOAD, 32'h200, BUS_LOAD, 32'h100, 64'h0, 4'd3, 4'd0, 64'h0);
        chk("t1_dc_resp", arb2dc_response,  4'd3);
        chk("t1_ic_resp", arb2ic_response,  4'd0);
        chk("t1_addr",    proc2mem_addr,    32'h100);
        chk("t1_cmd",     proc2mem_command, BUS_LOAD);
        idle(4'd3, 64'hDEAD_0003);
        chk("t1_dc_tag",  arb2dc_tag,  4'd3);
        chk("t1_dc_data", arb2dc_data, 64'hDEAD_0003);
        chk("t1_ic_tag",  arb2ic_tag,  4'd0);
        chk("t1_ic_data", arb2ic_data, 64'h0);

        // 2: icache locked by a stalled controller, dcache joins later.
        drive(BUS_LOAD, 32'h200, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
        chk("t2_addr0",   proc2mem_addr,   32'h200);
        chk("t2_ic_rsp0", arb2ic_response, 4'd0);
        drive(BUS_LOAD, 32'h200, BUS_LOAD, 32'h300, 64'hAB, 4'd0, 4'd0, 64'h0);
        chk("t2_state_lock", dut.state_q,   LOCK_IC);
        chk("t2_addr1",      proc2mem_addr, 32'h200);
        chk("t2_data1",      proc2mem_data, 64'h0);
        chk("t2_dc_rsp1",    arb2dc_response, 4'd0);
        drive(BUS_LOAD, 32'h200, BUS_LOAD, 32'h300, 64'hAB, 4'd0, 4'd0, 64'h0);
        chk("t2_addr2",      proc2mem_addr, 32'h200);
        drive(BUS_LOAD, 32'h200, BUS_LOAD, 32'h300, 64'hAB, 4'd5, 4'd0, 64'h0);
        chk("t2_ic_rsp5",    arb2ic_response, 4'd5);
        chk("t2_dc_rsp5",    arb2dc_response, 4'd0);
        idle(4'd5, 64'h5555);
        chk("t2_state_idle", dut.state_q, IDLE);
        chk("t2_ic_tag",     arb2ic_tag,  4'd5);
        chk("t2_ic_data",    arb2ic_data, 64'h5555);
        chk("t2_dc_tag",     arb2dc_tag,  4'd0);

        // 3: continuous contention; icache wins on its fifth cycle, then dcache.
        for (int k = 0; k < 6; k++) begin
            drive(BUS_LOAD, 32'h600, BUS_LOAD, 32'h700, 64'h0, 4'd1, 4'd0, 64'h0);
            chk($sformatf("t3_ic_rsp_%0d", k), arb2ic_response, (k == 4) ? 4'd1 : 4'd0);
            chk($sformatf("t3_dc_rsp_%0d", k), arb2dc_response, (k == 4) ? 4'd0 : 4'd1);
            chk($sformatf("t3_addr_%0d", k),   proc2mem_addr,   (k == 4) ? 32'h600 : 32'h700);
        end
        idle(4'd0, 64'h0);

        // 4: tag 7 completes to dcache while being re-issued to icache.
        drive(BUS_NONE, 32'h0, BUS_LOAD, 32'h800, 64'h0, 4'd7, 4'd0, 64'h0);
        chk("t4_dc_rsp", arb2dc_response, 4'd7);
        drive(BUS_LOAD, 32'h900, BUS_NONE, 32'h0, 64'h0, 4'd7, 4'd7, 64'hD1);
        chk("t4_ic_rsp",   arb2ic_response, 4'd7);
        chk("t4_dc_tag",   arb2dc_tag,      4'd7);
        chk("t4_dc_data",  arb2dc_data,     64'hD1);
        chk("t4_ic_tag0",  arb2ic_tag,      4'd0);
        idle(4'd7, 64'hD2);
        chk("t4_ic_tag",   arb2ic_tag,  4'd7);
        chk("t4_ic_data",  arb2ic_data, 64'hD2);
        chk("t4_dc_tag0",  arb2dc_tag,  4'd0);
        chk("t4_err",      arb_err,     1'b0);

        // 5: completion of an unowned tag is dropped and flagged.
        idle(4'd9, 64'h99);
        chk("t5_ic_tag",  arb2ic_tag,  4'd0);
        chk("t5_dc_tag",  arb2dc_tag,  4'd0);
        chk("t5_ic_data", arb2ic_data, 64'h0);
        chk("t5_dc_data", arb2dc_data, 64'h0);
        idle(4'd0, 64'h0);
        chk("t5_err_set", arb_err, 1'b1);
        idle(4'd0, 64'h0);
        chk("t5_err_sticky", arb_err, 1'b1);

        // 6: reset during LOCK_DC abandons the outstanding tag 0xA.
        drive(BUS_NONE, 32'h0, BUS_LOAD, 32'hA00, 64'h0, 4'hA, 4'd0, 64'h0);
        chk("t6_dc_rspA", arb2dc_response, 4'hA);
        drive(BUS_NONE, 32'h0, BUS_LOAD, 32'hB00, 64'hBB, 4'd0, 4'd0, 64'h0);
        chk("t6_addr",  proc2mem_addr, 32'hB00);
        chk("t6_data",  proc2mem_data, 64'hBB);
        drive(BUS_NONE, 32'h0, BUS_LOAD, 32'hB00, 64'hBB, 4'd0, 4'd0, 64'h0);
        chk("t6_state_lock", dut.state_q, LOCK_DC);
        #2;
        reset             = 1'b0;
        mem2proc_response = 4'd6;
        #1;
        chk("t6_rst_cmd",   proc2mem_command, BUS_NONE);
        chk("t6_rst_addr",  proc2mem_addr,    32'h0);
        chk("t6_rst_data",  proc2mem_data,    64'h0);
        chk("t6_rst_rsp",   arb2dc_response,  4'd0);
        chk("t6_rst_err",   arb_err,          1'b0);
        chk("t6_rst_state", dut.state_q,      IDLE);
        idle(4'd0, 64'h0);
        reset = 1'b1;
        idle(4'hA, 64'hAAAA);
        chk("t6_old_dc_tag", arb2dc_tag, 4'd0);
        chk("t6_old_ic_tag", arb2ic_tag, 4'd0);
        idle(4'd0, 64'h0);
        chk("t6_old_err", arb_err, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
